// File: rtl/elgamal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elgamal_pkg                                                          |
// | Shared widths and state encoding for the ElGamal arithmetic chain.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package elgamal_pkg;

  localparam int unsigned c_SIZE  = 128;
  localparam int unsigned c_HALF  = c_SIZE / 2;
  localparam int unsigned c_CNT_W = $clog2(c_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mr_state_t;

endpackage
`default_nettype wire

// File: rtl/mod_reduce_128_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_reduce_128_if                                                    |
// | Product/modulus input stream and remainder output stream.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mod_reduce_128_if #(
  parameter int SIZE = elgamal_pkg::c_SIZE
);
  logic [SIZE-1:0]   input_tdata;
  logic [SIZE/2-1:0] input_modulus;
  logic              input_tvalid;
  logic              input_tready;
  logic [SIZE/2-1:0] output_tdata;
  logic              output_terror;
  logic              output_tvalid;
  logic              output_tready;

  modport slave (
    input  input_tdata, input_modulus, input_tvalid, output_tready,
    output input_tready, output_tdata, output_terror, output_tvalid
  );

  modport master (
    output input_tdata, input_modulus, input_tvalid, output_tready,
    input  input_tready, output_tdata, output_terror, output_tvalid
  );
endinterface
`default_nettype wire

// File: rtl/mod_reduce_128_sub_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_sub_step                                                         |
// | One restoring-remainder step: shift in a bit, subtract m if t >= m.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mod_sub_step #(
  parameter int HALF = 64
) (
  input  logic [HALF:0]   i_r,
  input  logic            i_bit,
  input  logic [HALF-1:0] i_m,
  output logic [HALF:0]   o_r
);
  logic [HALF:0] w_t;
  logic [HALF:0] w_m;

  // r < m keeps the top bit of r clear, so shifting it out loses nothing
  assign w_t = (i_r << 1) | {{HALF{1'b0}}, i_bit};
  assign w_m = {1'b0, i_m};
  assign o_r = (w_t >= w_m) ? (w_t - w_m) : w_t;
endmodule
`default_nettype wire

// File: rtl/mod_reduce_128.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_reduce_128                                                       |
// | Bit-serial product mod modulus, one product bit per clock.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mod_reduce_128
  import elgamal_pkg::*;
#(
  parameter int SIZE = c_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  mod_reduce_128_if.slave   bus
);
  localparam int HALF  = SIZE / 2;
  localparam int CNT_W = $clog2(SIZE);

  mr_state_t         r_state;
  mr_state_t         w_state_next;
  logic [SIZE-1:0]   r_q;
  logic [HALF-1:0]   r_m;
  logic [HALF:0]     r_r;
  logic [HALF:0]     w_r_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [HALF-1:0]   r_data;
  logic              r_err;
  logic              w_in_fire;
  logic              w_out_fire;

  assign bus.input_tready  = (r_state == IDLE) && !rst;
  assign bus.output_tvalid = r_valid;
  assign bus.output_tdata  = r_data;
  assign bus.output_terror = r_err;

  assign w_in_fire  = bus.input_tvalid && bus.input_tready;
  assign w_out_fire = r_valid && bus.output_tready;

  mod_sub_step #(.HALF(HALF)) u_step (
    .i_r   (r_r),
    .i_bit (r_q[SIZE-1]),
    .i_m   (r_m),
    .o_r   (w_r_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_in_fire) w_state_next = (bus.input_modulus != '0) ? CALC : DONE;
      CALC: if (r_cnt == '0) w_state_next = DONE;
      DONE: if (w_out_fire) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      r_m     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_q    <= bus.input_tdata;
            r_m    <= bus.input_modulus;
            r_r    <= '0;
            r_cnt  <= CNT_W'(SIZE - 1);
            r_data <= '0;
            r_err  <= (bus.input_modulus == '0);
          end
        end
        CALC: begin
          r_r   <= w_r_next;
          r_q   <= r_q << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_data  <= w_r_next[HALF-1:0];
            r_err   <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        // Zero-modulus path enters here with valid low; it rises one edge later
        DONE: r_valid <= !w_out_fire;
        default: r_valid <= 1'b0;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mod_reduce_128.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mod_reduce_128                                                    |
// | Randomized self-checking bench against a plain-arithmetic model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mod_reduce_128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mod_reduce_128_if #(.SIZE(128)) bus ();

  mod_reduce_128 #(.SIZE(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with bp cycles of output backpressure
  task automatic do_op(input logic [127:0] prod, input logic [63:0] modl, input int bp);
    logic [127:0] full;
    logic [63:0]  exp_r;
    logic         exp_e;
    logic [63:0]  held;
    int           lat;
    exp_e = (modl == 64'd0);
    full  = exp_e ? 128'd0 : (prod % {64'd0, modl});
    exp_r = full[63:0];
    @(negedge clk);
    check_eq("in_ready_idle", {127'd0, bus.input_tready}, 128'd1);
    bus.input_tdata   = prod;
    bus.input_modulus = modl;
    bus.input_tvalid  = 1'b1;
    bus.output_tready = 1'b0;
    @(posedge clk); #1;
    bus.input_tvalid = 1'b0;
    check_eq("in_ready_busy", {127'd0, bus.input_tready}, 128'd0);
    lat = 0;
    while (!bus.output_tvalid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 128'(lat), exp_e ? 128'd1 : 128'd128);
    check_eq("result", {64'd0, bus.output_tdata}, {64'd0, exp_r});
    check_eq("terror", {127'd0, bus.output_terror}, {127'd0, exp_e});
    held = bus.output_tdata;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check_eq("bp_stable", {62'd0, bus.output_tvalid, bus.input_tready, bus.output_tdata},
               {62'd0, 1'b1, 1'b0, held});
    end
    @(negedge clk);
    bus.output_tready = 1'b1;
    @(posedge clk); #1;
    bus.output_tready = 1'b0;
    check_eq("post_hs", {126'd0, bus.output_tvalid, bus.input_tready}, 128'd1);
  endtask

  initial begin
    logic [127:0] p;
    logic [63:0]  m;
    int           seen;
    bus.input_tdata   = '0;
    bus.input_modulus = '0;
    bus.input_tvalid  = 1'b0;
    bus.output_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {127'd0, bus.input_tready}, 128'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    check_eq("reset_state", {61'd0, bus.output_tvalid, bus.output_terror, bus.input_tready, bus.output_tdata},
             {61'd0, 1'b0, 1'b0, 1'b1, 64'd0});

    // Directed cases
    do_op(128'd1000, 64'd7, 0);
    do_op(128'hFFFFFFFFFFFFFFFE0000000000000001, 64'hFFFFFFFFFFFFFFC5, 0);
    do_op(128'd5, 64'd9, 0);
    do_op(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 64'd1, 0);
    do_op(128'h1234, 64'd0, 2);
    do_op(128'd1000, 64'd7, 10);
    do_op(128'd2000, 64'd7, 0);

    // Reset in the middle of a computation
    @(negedge clk);
    bus.input_tdata   = 128'd1000;
    bus.input_modulus = 64'd7;
    bus.input_tvalid  = 1'b1;
    @(posedge clk); #1;
    bus.input_tvalid = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst", {62'd0, bus.output_tvalid, bus.input_tready, bus.output_tdata}, 128'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    check_eq("ready_after_rst", {127'd0, bus.input_tready}, 128'd1);
    seen = 0;
    bus.output_tready = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      if (bus.output_tvalid) seen++;
    end
    bus.output_tready = 1'b0;
    check_eq("no_stale", 128'(seen), 128'd0);
    do_op(128'd1000, 64'd7, 0);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      case (i % 4)
        0: m = {$urandom, $urandom};
        1: m = 64'($urandom_range(1, 1000));
        2: m = {1'b1, 31'($urandom), $urandom};
        default: m = (i == 7) ? 64'd0 : {32'd0, $urandom};
      endcase
      if (i % 5 == 0) p = {64'd0, 64'($urandom)};
      do_op(p, m, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
